// File: rtl/hmmm_seqmon_pkg.sv
// Shared types for the Hmmm I/O sequence monitor: FSM states, failure codes
// and the sequence-length clamp.
package hmmm_seqmon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE  = 2'b00;
  localparam logic [1:0] FC_TMO   = 2'b01;
  localparam logic [1:0] FC_UNEXP = 2'b10;
  localparam logic [1:0] FC_ABORT = 2'b11;

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/hmmm_seqmon_regfile.sv
// Expected-value store for the sequence monitor: one write port, combinational
// read. Contents survive reset so a rerun needs no reload.
module hmmm_seqmon_regfile #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hmmm_io_seq_monitor.sv
// Checks the output bus against a programmed sequence with per-step timeout and
// glitch filter. Define HMMM_SEQMON_STRICT_EN to fail on unexpected bus values.
module hmmm_io_seq_monitor
  import hmmm_seqmon_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int DEPTH  = 16,
  parameter  int TMO_W  = 16,
  parameter  int STABLE = 1,
  localparam int AW     = $clog2(DEPTH),
  localparam int SW     = AW + 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic [SW-1:0]    cfg_len,
  input  logic [TMO_W-1:0] tmo_lim,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] obs_i,
  output logic             busy_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic [1:0]       fail_code_o,
  output logic [SW-1:0]    step_o
);

  localparam int CW = $clog2(STABLE + 1);

  state_e           state_q;
  logic [WIDTH-1:0] obs_q;
  logic [WIDTH-1:0] exp_val;
  logic [SW-1:0]    len_q, step_q;
  logic [TMO_W-1:0] lim_q, tmo_q;
  logic [CW-1:0]    stab_q;
  logic             busy_q, pass_q, fail_q;
  logic [1:0]       code_q;

  logic             cfg_wr;
  logic             hit, accept, tmo_hit, unexp;
  logic [SW-1:0]    step_d, len_d;

  hmmm_seqmon_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_regfile (
    .clk_i   (wb_clk_i),
    .we_i    (cfg_wr),
    .waddr_i (cfg_addr),
    .wdata_i (cfg_data),
    .raddr_i (step_q[AW-1:0]),
    .rdata_o (exp_val)
  );

  // The step counter doubles as the read index into the expected-value store.
  assign cfg_wr  = cfg_we && (state_q != WAIT);
  assign hit     = (obs_q == exp_val);
  assign accept  = hit && (stab_q == CW'(STABLE - 1));
  assign tmo_hit = (lim_q != '0) && (tmo_q == lim_q - TMO_W'(1));
  assign step_d  = step_q + SW'(1);
  assign len_d   = SW'(clamp_len(32'(cfg_len), DEPTH));

`ifdef HMMM_SEQMON_STRICT_EN
  logic [WIDTH-1:0] prev_q;
  assign unexp = !hit && (obs_q != prev_q);
`else
  assign unexp = 1'b0;
`endif

  // The bus sample is taken every cycle, reset or not.
  always_ff @(posedge wb_clk_i) begin
    obs_q <= obs_i;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      lim_q   <= '0;
      step_q  <= '0;
      tmo_q   <= '0;
      stab_q  <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      code_q  <= FC_NONE;
`ifdef HMMM_SEQMON_STRICT_EN
      prev_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, PASS, FAIL: begin
          if (start) begin
            len_q  <= len_d;
            lim_q  <= tmo_lim;
            step_q <= '0;
            tmo_q  <= '0;
            stab_q <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
            code_q <= FC_NONE;
`ifdef HMMM_SEQMON_STRICT_EN
            prev_q <= '0;
`endif
            if (len_d == '0) begin
              state_q <= PASS;
              pass_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= WAIT;
              busy_q  <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (abort) begin
            state_q <= FAIL;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
            code_q  <= FC_ABORT;
          end else if (accept) begin
            step_q <= step_d;
            tmo_q  <= '0;
            stab_q <= '0;
`ifdef HMMM_SEQMON_STRICT_EN
            prev_q <= obs_q;
`endif
            if (step_d == len_q) begin
              state_q <= PASS;
              busy_q  <= 1'b0;
              pass_q  <= 1'b1;
            end
          end else if (unexp) begin
            state_q <= FAIL;
            busy_q  <= 1'b0;
            fail_q  <= 1'b1;
            code_q  <= FC_UNEXP;
          end else begin
            stab_q <= hit ? stab_q + CW'(1) : '0;
            if (tmo_hit) begin
              state_q <= FAIL;
              busy_q  <= 1'b0;
              fail_q  <= 1'b1;
              code_q  <= FC_TMO;
            end else if (tmo_q != '1) begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign pass_o      = pass_q;
  assign fail_o      = fail_q;
  assign fail_code_o = code_q;
  assign step_o      = step_q;

endmodule
